// File: rtl/id_ex_control.sv
// Main control decoder and ID/EX pipeline register for the five-stage MIPS pipeline.
// Also generates load-use stall enables and squashes ID/EX on a redirect.
module id_ex_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        ex_flush,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ex_valid,
  output logic [1:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_regdst,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_regwrite,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [5:0]  ex_funct,
  output logic [31:0] ex_imm,
  output logic [25:0] ex_jtarget,
  output logic        illegal_op,
  output logic [7:0]  illegal_count
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  // Bundle layout: regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, aluop[1:0]
  logic [9:0]  w_ctl;
  logic        w_illegal;
  logic        w_rt_src;
  logic        w_hz;
  logic [5:0]  w_op;

  logic [9:0]  r_ctl;
  logic        r_valid;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [5:0]  r_funct;
  logic [31:0] r_imm;
  logic [25:0] r_jtarget;
  logic        r_illegal;
  logic [7:0]  r_cnt;

  assign w_op = id_instr[31:26];

  always_comb begin
    w_ctl     = '0;
    w_illegal = 1'b0;
    w_rt_src  = 1'b0;
    case (w_op)
      OP_RTYPE: begin w_ctl = 10'b1001_0000_10; w_rt_src = 1'b1; end
      OP_LW:    w_ctl = 10'b0111_1000_00;
      OP_SW:    begin w_ctl = 10'b0100_0100_00; w_rt_src = 1'b1; end
      OP_BEQ:   begin w_ctl = 10'b0000_0010_01; w_rt_src = 1'b1; end
      OP_ADDI:  w_ctl = 10'b0101_0000_00;
      OP_ORI:   w_ctl = 10'b0101_0000_11;
      OP_J:     w_ctl = 10'b0000_0001_00;
      default:  w_illegal = 1'b1;
    endcase
  end

  // rs is always treated as a source; rt only when the opcode actually reads it.
  assign w_hz = r_valid & r_ctl[5] & (r_rt != 5'd0) & id_valid &
                ((r_rt == id_instr[25:21]) | ((r_rt == id_instr[20:16]) & w_rt_src));

  // A redirect overrides the stall so the fetch can move to the new target.
  assign pc_write   = ~(w_hz & ~ex_flush);
  assign ifid_write = ~(w_hz & ~ex_flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl     <= '0;
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_funct   <= '0;
      r_imm     <= '0;
      r_jtarget <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_rs      <= id_instr[25:21];
      r_rt      <= id_instr[20:16];
      r_rd      <= id_instr[15:11];
      r_funct   <= id_instr[5:0];
      r_imm     <= {{16{id_instr[15]}}, id_instr[15:0]};
      r_jtarget <= id_instr[25:0];
      r_illegal <= 1'b0;
      if (ex_flush || w_hz || !id_valid) begin
        r_valid <= 1'b0;
        r_ctl   <= '0;
      end else begin
        r_valid   <= 1'b1;
        r_ctl     <= w_ctl;
        r_illegal <= w_illegal;
        if (w_illegal && (r_cnt != 8'hFF))
          r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_regdst     = r_ctl[9];
  assign ex_alusrc     = r_ctl[8];
  assign ex_memtoreg   = r_ctl[7];
  assign ex_regwrite   = r_ctl[6];
  assign ex_memread    = r_ctl[5];
  assign ex_memwrite   = r_ctl[4];
  assign ex_branch     = r_ctl[3];
  assign ex_jump       = r_ctl[2];
  assign ex_aluop      = r_ctl[1:0];
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign ex_imm        = r_imm;
  assign ex_jtarget    = r_jtarget;
  assign illegal_op    = r_illegal;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed self-checking bench for id_ex_control with hand-computed expectations.
module tb_id_ex_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_flush;
  logic        pc_write, ifid_write, ex_valid;
  logic [1:0]  ex_aluop;
  logic        ex_alusrc, ex_regdst, ex_memread, ex_memwrite;
  logic        ex_memtoreg, ex_regwrite, ex_branch, ex_jump;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [31:0] ex_imm;
  logic [25:0] ex_jtarget;
  logic        illegal_op;
  logic [7:0]  illegal_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_control dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .ex_flush(ex_flush),
    .pc_write(pc_write), .ifid_write(ifid_write), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .ex_imm(ex_imm), .ex_jtarget(ex_jtarget),
    .illegal_op(illegal_op), .illegal_count(illegal_count)
  );

  // regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, aluop
  logic [9:0] obs_ctl;
  assign obs_ctl = {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
                    ex_memread, ex_memwrite, ex_branch, ex_jump, ex_aluop};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sw_instr [7];
  logic [9:0]  sw_ctl   [7];
  logic [1:0]  sw_aluop [7];
  logic [6:0]  sw_stall;

  initial begin
    sw_instr = '{32'h00221820, 32'h8C220004, 32'hAC220004, 32'h10220003,
                 32'h20220005, 32'h34220005, 32'h08000010};
    sw_ctl   = '{10'b1001000010, 10'b0111100000, 10'b0100010000, 10'b0000001001,
                 10'b0101000000, 10'b0101000011, 10'b0000000100};
    sw_aluop = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
    // sw reads rt=$2 right behind lw $2, so it stalls once
    sw_stall = 7'b0000100;

    rst = 1'b1; id_valid = 1'b1; id_instr = 32'h8C220004; ex_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_valid", ex_valid, 0);
      check_eq("rst_ctl", obs_ctl, 0);
      check_eq("rst_cnt", illegal_count, 0);
      check_eq("rst_illop", illegal_op, 0);
      check_eq("rst_pcw", pc_write, 1);
      check_eq("rst_ifidw", ifid_write, 1);
    end
    rst = 1'b0;

    // Decode sweep
    for (int i = 0; i < 7; i++) begin
      id_instr = sw_instr[i];
      #1;
      check_eq("sweep_pcw", pc_write, !sw_stall[i]);
      if (sw_stall[i]) begin
        tick();
        check_eq("sweep_bubble_valid", ex_valid, 0);
        check_eq("sweep_bubble_ctl", obs_ctl, 0);
        check_eq("sweep_after_stall_pcw", pc_write, 1);
      end
      tick();
      check_eq("sweep_valid", ex_valid, 1);
      check_eq("sweep_ctl", obs_ctl, sw_ctl[i]);
      check_eq("sweep_aluop", ex_aluop, sw_aluop[i]);
      if (i == 0) begin
        check_eq("add_rs", ex_rs, 1);
        check_eq("add_rt", ex_rt, 2);
        check_eq("add_rd", ex_rd, 3);
        check_eq("add_funct", ex_funct, 6'h20);
      end
      if (i == 1 || i == 2) check_eq("ldst_imm", ex_imm, 32'h00000004);
      if (i == 6) check_eq("j_target", ex_jtarget, 26'h0000010);
    end

    // Negative immediate sign extension through addi -1
    id_instr = 32'h2022FFFF;
    tick();
    check_eq("imm_signext", ex_imm, 32'hFFFFFFFF);

    // Load-use stall
    id_instr = 32'h8C020000;
    tick();
    check_eq("lu_lw_memread", ex_memread, 1);
    id_instr = 32'h00411820;
    #1;
    check_eq("lu_pcw", pc_write, 0);
    check_eq("lu_ifidw", ifid_write, 0);
    tick();
    check_eq("lu_bubble_valid", ex_valid, 0);
    check_eq("lu_bubble_ctl", obs_ctl, 0);
    check_eq("lu_release_pcw", pc_write, 1);
    tick();
    check_eq("lu_add_valid", ex_valid, 1);
    check_eq("lu_add_ctl", obs_ctl, 10'b1001000010);
    check_eq("lu_add_rd", ex_rd, 3);

    // lw $0 never stalls, even with a matching $0 source
    id_instr = 32'h8C000000;
    tick();
    id_instr = 32'h00011820;
    #1;
    check_eq("lw0_pcw", pc_write, 1);
    tick();
    check_eq("lw0_add_valid", ex_valid, 1);

    // rt is a destination for addi: no stall on rt match (lw $2 then addi $2,$1,5)
    id_instr = 32'h8C020000;
    tick();
    id_instr = 32'h20220005;
    #1;
    check_eq("rtdst_pcw", pc_write, 1);
    tick();
    check_eq("rtdst_valid", ex_valid, 1);

    // Flush wins over hazard
    id_instr = 32'h8C020000;
    tick();
    id_instr = 32'h00411820; ex_flush = 1'b1;
    #1;
    check_eq("fh_pcw", pc_write, 1);
    check_eq("fh_ifidw", ifid_write, 1);
    tick();
    check_eq("fh_valid", ex_valid, 0);
    check_eq("fh_ctl", obs_ctl, 0);
    ex_flush = 1'b0;
    tick();
    check_eq("fh_add_valid", ex_valid, 1);
    ex_flush = 1'b1;
    tick();
    check_eq("flush_valid", ex_valid, 0);
    check_eq("flush_ctl", obs_ctl, 0);
    ex_flush = 1'b0;

    // id_valid low loads a bubble
    id_valid = 1'b0;
    tick();
    check_eq("novalid_valid", ex_valid, 0);
    check_eq("novalid_ctl", obs_ctl, 0);
    id_valid = 1'b1;

    // Illegal opcode saturation
    id_instr = 32'hFC000000;
    for (int i = 1; i <= 300; i++) begin
      tick();
      check_eq("ill_ctl", obs_ctl, 0);
      check_eq("ill_op", illegal_op, 1);
      check_eq("ill_cnt", illegal_count, (i > 255) ? 255 : i);
    end
    id_instr = 32'h00221820;
    tick();
    check_eq("ill_clear", illegal_op, 0);
    check_eq("ill_hold", illegal_count, 255);

    // Reset during a stall cycle
    id_instr = 32'h8C020000;
    tick();
    id_instr = 32'h00411820;
    #1;
    check_eq("rms_stall_pcw", pc_write, 0);
    rst = 1'b1;
    tick();
    check_eq("rms_valid", ex_valid, 0);
    check_eq("rms_pcw", pc_write, 1);
    check_eq("rms_cnt", illegal_count, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_control.md
# id_ex_control

Main control decoder and ID/EX pipeline register for the five-stage MIPS pipeline. It decodes the opcode of the instruction in ID into the control bundle, including the 2-bit `aluop` that the EX-stage ALU control decodes together with `funct`. It registers that bundle and the operand fields into ID/EX. It also detects load-use hazards and inserts one-cycle bubbles, and squashes ID/EX on a branch/jump flush.

## Interface

No parameters.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_instr` in 32: instruction in ID.
- `ex_flush` in 1: branch/jump redirect; squash the instruction entering EX.
- `pc_write` out 1: PC update enable; 0 during a load-use stall.
- `ifid_write` out 1: IF/ID update enable; 0 during a load-use stall.
- `ex_valid` out 1: ID/EX holds a real instruction.
- `ex_aluop` out 2: 00 = add, 01 = sub (beq), 10 = R-type/funct, 11 = immediate logical.
- `ex_alusrc`, `ex_regdst`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_regwrite`, `ex_branch`, `ex_jump` out 1 each: registered control bits.
- `ex_rs`, `ex_rt`, `ex_rd` out 5 each: instr[25:21], [20:16], [15:11].
- `ex_funct` out 6: instr[5:0].
- `ex_imm` out 32: sign-extended instr[15:0].
- `ex_jtarget` out 26: instr[25:0].
- `illegal_op` out 1: registered; 1 for one cycle after an unknown opcode is accepted into ID/EX.
- `illegal_count` out 8: saturating count of illegal opcodes accepted.

## Operation

- Decode on instr[31:26]. Bits listed in this order: regdst/alusrc/memtoreg/regwrite/memread/memwrite/branch/jump, followed by aluop.
  - 000000 R-type: 1/0/0/1/0/0/0/0, aluop 10.
  - 100011 lw: 0/1/1/1/1/0/0/0, aluop 00.
  - 101011 sw: 0/1/0/0/0/1/0/0, aluop 00.
  - 000100 beq: 0/0/0/0/0/0/1/0, aluop 01.
  - 001000 addi: 0/1/0/1/0/0/0/0, aluop 00.
  - 001101 ori: 0/1/0/1/0/0/0/0, aluop 11.
  - 000010 j: all 0 except jump = 1, aluop 00.
  - Any other opcode: all control bits 0, aluop 00, flagged illegal.
- Bubble: `ex_valid` = 0 and all control bits = 0. Field outputs (`ex_rs`, `ex_rt`, etc.) are don't-care.
- Load-use hazard (combinational), `hz` = `ex_valid` & `ex_memread` & (`ex_rt` != 0) & `id_valid` & (`ex_rt` == instr[25:21] | (`ex_rt` == instr[20:16] & rt-is-source)).
  - rt-is-source is true for R-type, sw and beq only.
- `pc_write` = `ifid_write` = ~(`hz` & ~`ex_flush`).
- ID/EX load priority each cycle:
  1. `rst`: everything cleared.
  2. `ex_flush`: load a bubble.
  3. `hz`: load a bubble; IF/ID and PC hold, so the same instruction is re-presented next cycle.
  4. `id_valid` = 0: load a bubble.
  5. Otherwise: load the decoded instruction with `ex_valid` = 1.
- `illegal_op` is set only when case 5 loads an illegal opcode, and cleared otherwise.
- `illegal_count` increments on the same condition and saturates at 255.

## Timing

- Decode-to-EX latency is 1 cycle. Values registered on edge N are visible after edge N.
- Reset values: all ID/EX outputs 0, `ex_valid` = 0, `illegal_op` = 0, `illegal_count` = 0.
  - Consequently `pc_write` = `ifid_write` = 1 during and after reset.
- A load-use stall lasts exactly 1 cycle. After the bubble is loaded, `ex_memread` = 0, so `hz` drops.
- Flush and hazard in the same cycle: the flush wins; `pc_write` = `ifid_write` = 1, since the fetch redirect must proceed.
- Reset asserted mid-stall: the next edge clears ID/EX and the stall releases; no instruction survives.
- An lw that targets $0 never stalls.
- A dependent instruction whose rt is a destination (lw, addi, ori) does not stall on an rt match.

## Test plan

- Reset: hold `rst` 2 cycles with `id_valid` = 1 and `id_instr` = 0x8C220004.
  - Required: `ex_valid` = 0, all control bits 0, `illegal_count` = 0, `pc_write` = 1 throughout reset.
- Decode sweep: apply add (0x00221820), lw (0x8C220004), sw (0xAC220004), beq (0x10220003), addi (0x20220005), ori (0x34220005), j (0x08000010), one per cycle.
  - Required: the bundles above, each 1 cycle later.
  - Required: `ex_imm` = 0x00000004 for lw and sw.
  - Required: `ex_aluop` sequence 10, 00, 00, 01, 00, 11, 00.
- Load-use stall: lw $2 (0x8C020000) followed by add $3,$2,$1 (0x00411820).
  - Required: 1 cycle of `pc_write` = 0 and `ifid_write` = 0, then a bubble in EX, then the add in EX.
  - Same pair with lw $0 as the destination: no stall.
- Flush versus hazard: same lw/add pair with `ex_flush` = 1 in the hazard cycle.
  - Required: `pc_write` = 1 and a bubble in EX.
  - `ex_flush` alone on a valid add: required a bubble in EX.
- Illegal opcode: present opcode 111111 300 times consecutively.
  - Required: all control bits 0 and `illegal_op` = 1 each cycle.
  - Required: `illegal_count` saturates at 255.
- Reset mid-stall: assert `rst` in the stall cycle.
  - Required: next cycle `ex_valid` = 0 and `pc_write` = 1.
